// File: rtl/cg_pkg.sv
// cg_pkg: register map, status bit positions and control-field layout for cg_creg
package cg_pkg;
  localparam int W24 = 24;
  localparam int A_CTRL = 0;
  localparam int A_DLY = 1;
  localparam int A_LMT = 4;
  localparam int A_STAT = 7;
  localparam int A_CAP = 8;
  localparam int N_REG = 11;
  localparam int ST_RTE = 0;
  localparam int ST_CAP = 1;
  localparam int ST_BUSY = 2;
  typedef struct packed {
    logic len;
    logic lds;
    logic dds;
    logic oe;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/cg_stage24.sv
// cg_stage24: 24-bit register written bytewise, low/mid staged, high byte commits all three
module cg_stage24
  import cg_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     we_i,
  input  logic [7:0]     wdata_i,
  output logic [W24-1:0] val_o
);
  logic [7:0] lo_q, mid_q;
  logic [W24-1:0] val_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      mid_q <= '0;
      val_q <= '0;
    end else begin
      if (we_i[0]) lo_q <= wdata_i;
      if (we_i[1]) mid_q <= wdata_i;
      if (we_i[2]) val_q <= {wdata_i, mid_q, lo_q};
    end
  end
  assign val_o = val_q;
endmodule

// File: rtl/cg_creg.sv
// cg_creg: host-visible config/status register block for the core
module cg_creg
  import cg_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              I_RST,
  input  logic              I_WE,
  input  logic              I_RE,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic [7:0]        I_WDATA,
  output logic [7:0]        O_RDATA,
  output logic              O_RVALID,
  output logic [W24-1:0]    O_LMT,
  output logic [W24-1:0]    O_DLY,
  output logic              O_OE,
  output logic              O_EN,
  output logic              O_DDS,
  output logic              O_LDS,
  output logic              O_LEN,
  input  logic [W24-1:0]    I_ACC,
  input  logic              I_SOE,
  input  logic              I_RTE
);
  logic [N_REG-1:0] sel;
  logic [7:0] rdata_d, st_v;
  logic [W24-1:0] cap_q, hold_q;
  ctrl_t ctrl_q;
  logic rd, st_rd, cap_rd, rte_q, soe_q, rte_set, cap_ev, sticky_q, capv_q;
  always_comb for (int k = 0; k < N_REG; k++) sel[k] = (I_ADDR == ADDR_W'(k));
  assign rd = I_RE & ~I_WE;
  assign st_rd = rd & sel[A_STAT];
  assign cap_rd = rd & sel[A_CAP];
  assign rte_set = I_RTE & ~rte_q;
  assign cap_ev = soe_q & ~I_SOE;
  cg_stage24 u_dly (.clk(clk), .rst(I_RST), .we_i({3{I_WE}} & sel[A_DLY+2:A_DLY]), .wdata_i(I_WDATA), .val_o(O_DLY));
  cg_stage24 u_lmt (.clk(clk), .rst(I_RST), .we_i({3{I_WE}} & sel[A_LMT+2:A_LMT]), .wdata_i(I_WDATA), .val_o(O_LMT));
  always_comb begin
    st_v = '0;
    st_v[ST_RTE] = sticky_q;
    st_v[ST_CAP] = capv_q;
    st_v[ST_BUSY] = I_SOE;
  end
  // CAP mid/high bytes come from the snapshot taken at the low-byte read
  assign rdata_d = sel[A_CTRL]  ? 8'(ctrl_q)     :
                   sel[A_DLY]   ? O_DLY[7:0]     :
                   sel[A_DLY+1] ? O_DLY[15:8]    :
                   sel[A_DLY+2] ? O_DLY[23:16]   :
                   sel[A_LMT]   ? O_LMT[7:0]     :
                   sel[A_LMT+1] ? O_LMT[15:8]    :
                   sel[A_LMT+2] ? O_LMT[23:16]   :
                   sel[A_STAT]  ? st_v           :
                   sel[A_CAP]   ? cap_q[7:0]     :
                   sel[A_CAP+1] ? hold_q[15:8]   :
                   sel[A_CAP+2] ? hold_q[23:16]  : 8'h00;
  always_ff @(posedge clk) begin
    if (I_RST) begin
      ctrl_q <= '0;
      rte_q <= 1'b0;
      soe_q <= 1'b0;
      sticky_q <= 1'b0;
      capv_q <= 1'b0;
      cap_q <= '0;
      hold_q <= '0;
      O_RDATA <= '0;
      O_RVALID <= 1'b0;
    end else begin
      if (I_WE && sel[A_CTRL]) ctrl_q <= ctrl_t'(I_WDATA[4:0]);
      rte_q <= I_RTE;
      soe_q <= I_SOE;
      sticky_q <= rte_set | (sticky_q & ~st_rd);
      capv_q <= cap_ev | (capv_q & ~st_rd);
      if (cap_ev) cap_q <= I_ACC;
      if (cap_rd) hold_q <= cap_q;
      O_RVALID <= rd;
      if (rd) O_RDATA <= rdata_d;
    end
  end
  assign O_EN = ctrl_q.en;
  assign O_OE = ctrl_q.oe;
  assign O_DDS = ctrl_q.dds;
  assign O_LDS = ctrl_q.lds;
  assign O_LEN = ctrl_q.len;
endmodule

// File: tb/tb_cg_creg.sv
// tb_cg_creg: directed self-checking bench for cg_creg
module tb_cg_creg;
  logic clk = 1'b0;
  logic I_RST, I_WE, I_RE, I_SOE, I_RTE;
  logic [3:0] I_ADDR;
  logic [7:0] I_WDATA, O_RDATA;
  logic O_RVALID, O_OE, O_EN, O_DDS, O_LDS, O_LEN;
  logic [23:0] O_LMT, O_DLY, I_ACC;
  int n_cmp = 0;
  int n_bad = 0;

  cg_creg #(.ADDR_W(4)) dut (
    .clk(clk), .I_RST(I_RST), .I_WE(I_WE), .I_RE(I_RE), .I_ADDR(I_ADDR), .I_WDATA(I_WDATA),
    .O_RDATA(O_RDATA), .O_RVALID(O_RVALID), .O_LMT(O_LMT), .O_DLY(O_DLY),
    .O_OE(O_OE), .O_EN(O_EN), .O_DDS(O_DDS), .O_LDS(O_LDS), .O_LEN(O_LEN),
    .I_ACC(I_ACC), .I_SOE(I_SOE), .I_RTE(I_RTE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    I_WE = 1'b1; I_ADDR = a; I_WDATA = d;
    tick();
    I_WE = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    I_RE = 1'b1; I_ADDR = a;
    tick();
    I_RE = 1'b0;
  endtask

  task automatic test_reset();
    I_RST = 1'b1; I_WE = 1'b0; I_RE = 1'b0; I_ADDR = '0; I_WDATA = '0;
    I_ACC = '0; I_SOE = 1'b0; I_RTE = 1'b0;
    tick(); tick();
    I_RST = 1'b0;
    n_cmp++;
    if ({O_DLY, O_LMT, O_RDATA, O_RVALID, O_OE, O_EN, O_DDS, O_LDS, O_LEN} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got dly=%h lmt=%h rdata=%h rvalid=%b ctrl=%b%b%b%b%b want all 0",
        O_DLY, O_LMT, O_RDATA, O_RVALID, O_LEN, O_LDS, O_DDS, O_OE, O_EN);
    end
    rd(4'h7);
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'h00) begin
      n_bad++; $display("FAIL reset_status: got rvalid=%b rdata=%h want 1/00", O_RVALID, O_RDATA);
    end
  endtask

  task automatic test_dly_commit();
    wr(4'h1, 8'h56);
    wr(4'h2, 8'h34);
    n_cmp++;
    if (O_DLY !== 24'h0) begin n_bad++; $display("FAIL dly_staged: got %h want 000000", O_DLY); end
    wr(4'h3, 8'h12);
    n_cmp++;
    if (O_DLY !== 24'h123456) begin n_bad++; $display("FAIL dly_commit: got %h want 123456", O_DLY); end
    wr(4'h1, 8'h99);
    rd(4'h1);
    n_cmp++;
    if (O_RDATA !== 8'h56 || O_DLY !== 24'h123456) begin
      n_bad++; $display("FAIL dly_read_committed: got rdata=%h dly=%h want 56/123456", O_RDATA, O_DLY);
    end
  endtask

  task automatic test_ctrl();
    wr(4'h0, 8'h13);
    n_cmp++;
    if ({O_EN, O_OE, O_DDS, O_LDS, O_LEN} !== 5'b11001) begin
      n_bad++; $display("FAIL ctrl_outputs: got en/oe/dds/lds/len=%b want 11001", {O_EN, O_OE, O_DDS, O_LDS, O_LEN});
    end
    rd(4'h0);
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'h13) begin
      n_bad++; $display("FAIL ctrl_read: got rvalid=%b rdata=%h want 1/13", O_RVALID, O_RDATA);
    end
    tick();
    n_cmp++;
    if (O_RVALID !== 1'b0 || O_RDATA !== 8'h13) begin
      n_bad++; $display("FAIL rdata_hold: got rvalid=%b rdata=%h want 0/13", O_RVALID, O_RDATA);
    end
  endtask

  task automatic test_capture();
    I_ACC = 24'h00A0F0; I_SOE = 1'b1;
    tick();
    I_SOE = 1'b0;
    tick();
    I_ACC = 24'h555555;
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h02) begin n_bad++; $display("FAIL cap_status: got %h want 02", O_RDATA); end
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h00) begin n_bad++; $display("FAIL cap_status_cleared: got %h want 00", O_RDATA); end
    rd(4'h8);
    n_cmp++;
    if (O_RDATA !== 8'hF0) begin n_bad++; $display("FAIL cap_lo: got %h want F0", O_RDATA); end
    rd(4'h9);
    n_cmp++;
    if (O_RDATA !== 8'hA0) begin n_bad++; $display("FAIL cap_mid: got %h want A0", O_RDATA); end
    rd(4'hA);
    n_cmp++;
    if (O_RDATA !== 8'h00) begin n_bad++; $display("FAIL cap_hi: got %h want 00", O_RDATA); end
  endtask

  task automatic test_cap_coherent();
    rd(4'h8);
    I_SOE = 1'b1;
    tick();
    I_ACC = 24'h111111; I_SOE = 1'b0;
    tick();
    rd(4'h9);
    n_cmp++;
    if (O_RDATA !== 8'hA0) begin n_bad++; $display("FAIL cap_hold_mid: got %h want A0", O_RDATA); end
    rd(4'h8);
    n_cmp++;
    if (O_RDATA !== 8'h11) begin n_bad++; $display("FAIL cap_new_lo: got %h want 11", O_RDATA); end
    rd(4'hA);
    n_cmp++;
    if (O_RDATA !== 8'h11) begin n_bad++; $display("FAIL cap_new_hi: got %h want 11", O_RDATA); end
    rd(4'h7);
  endtask

  task automatic test_rte_race();
    I_RTE = 1'b1;
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h00) begin n_bad++; $display("FAIL rte_race_old: got %h want 00", O_RDATA); end
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h01) begin n_bad++; $display("FAIL rte_race_set: got %h want 01", O_RDATA); end
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h00) begin n_bad++; $display("FAIL rte_level_no_reset: got %h want 00", O_RDATA); end
    I_RTE = 1'b0;
    I_SOE = 1'b1;
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h04) begin n_bad++; $display("FAIL busy_live: got %h want 04", O_RDATA); end
    I_SOE = 1'b0;
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h00) begin n_bad++; $display("FAIL cap_race_old: got %h want 00", O_RDATA); end
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h02) begin n_bad++; $display("FAIL cap_race_set: got %h want 02", O_RDATA); end
  endtask

  task automatic test_unmapped_and_we_re();
    I_WE = 1'b1; I_RE = 1'b1; I_ADDR = 4'h0; I_WDATA = 8'h05;
    tick();
    I_WE = 1'b0; I_RE = 1'b0;
    n_cmp++;
    if (O_RVALID !== 1'b0 || {O_EN, O_OE, O_DDS, O_LDS, O_LEN} !== 5'b10100) begin
      n_bad++; $display("FAIL we_re_both: got rvalid=%b ctrl=%b want 0/10100", O_RVALID, {O_EN, O_OE, O_DDS, O_LDS, O_LEN});
    end
    wr(4'h8, 8'hFF);
    wr(4'h7, 8'hFF);
    wr(4'hB, 8'hFF);
    rd(4'h8);
    n_cmp++;
    if (O_RDATA !== 8'h11) begin n_bad++; $display("FAIL cap_write_ignored: got %h want 11", O_RDATA); end
    rd(4'hB);
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'h00) begin
      n_bad++; $display("FAIL unmapped_B: got rvalid=%b rdata=%h want 1/00", O_RVALID, O_RDATA);
    end
    rd(4'h0);
    rd(4'hF);
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'h00) begin
      n_bad++; $display("FAIL unmapped_F: got rvalid=%b rdata=%h want 1/00", O_RVALID, O_RDATA);
    end
  endtask

  task automatic test_back_to_back();
    I_WE = 1'b1;
    I_ADDR = 4'h4; I_WDATA = 8'hAA; tick();
    I_ADDR = 4'h5; I_WDATA = 8'hBB; tick();
    I_ADDR = 4'h6; I_WDATA = 8'hCC; tick();
    I_WE = 1'b0; I_RE = 1'b1;
    n_cmp++;
    if (O_LMT !== 24'hCCBBAA) begin n_bad++; $display("FAIL b2b_lmt: got %h want CCBBAA", O_LMT); end
    I_ADDR = 4'h4; tick();
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'hAA) begin n_bad++; $display("FAIL b2b_rd4: got %b/%h want 1/AA", O_RVALID, O_RDATA); end
    I_ADDR = 4'h5; tick();
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'hBB) begin n_bad++; $display("FAIL b2b_rd5: got %b/%h want 1/BB", O_RVALID, O_RDATA); end
    I_ADDR = 4'h6; tick();
    I_RE = 1'b0;
    n_cmp++;
    if (O_RVALID !== 1'b1 || O_RDATA !== 8'hCC) begin n_bad++; $display("FAIL b2b_rd6: got %b/%h want 1/CC", O_RVALID, O_RDATA); end
  endtask

  task automatic test_rst_midseq();
    wr(4'h4, 8'hFF);
    I_RST = 1'b1; I_WE = 1'b1; I_RE = 1'b1; I_ADDR = 4'h6; I_WDATA = 8'h77; I_SOE = 1'b1;
    tick();
    I_RST = 1'b0; I_WE = 1'b0; I_RE = 1'b0; I_SOE = 1'b0;
    n_cmp++;
    if ({O_DLY, O_LMT, O_RDATA, O_RVALID, O_OE, O_EN, O_DDS, O_LDS, O_LEN} !== '0) begin
      n_bad++; $display("FAIL midseq_reset: got dly=%h lmt=%h rdata=%h rvalid=%b ctrl=%b%b%b%b%b want all 0",
        O_DLY, O_LMT, O_RDATA, O_RVALID, O_LEN, O_LDS, O_DDS, O_OE, O_EN);
    end
    wr(4'h6, 8'h01);
    n_cmp++;
    if (O_LMT !== 24'h010000) begin n_bad++; $display("FAIL midseq_commit: got %h want 010000", O_LMT); end
    rd(4'h7);
    n_cmp++;
    if (O_RDATA !== 8'h00) begin n_bad++; $display("FAIL midseq_status: got %h want 00", O_RDATA); end
  endtask

  initial begin
    test_reset();
    test_dly_commit();
    test_ctrl();
    test_capture();
    test_cap_coherent();
    test_rte_race();
    test_unmapped_and_we_re();
    test_back_to_back();
    test_rst_midseq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cg_creg.md
CG_CREG -- requirements
Module: cg_creg

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, host address width; addresses at or above 0xB decode as unmapped.
REQ-002 SHALL have ports: clk  in  1  sole clock; I_RST  in  1  synchronous active-high reset.
REQ-003 SHALL have host ports: I_WE in 1 write strobe; I_RE in 1 read strobe; I_ADDR in ADDR_W register address; I_WDATA in 8 write byte.
REQ-004 SHALL have host outputs: O_RDATA out 8 read byte; O_RVALID out 1 read-data-valid pulse.
REQ-005 SHALL have core-config outputs: O_LMT out 24; O_DLY out 24; O_OE, O_EN, O_DDS, O_LDS, O_LEN out 1 each.
REQ-006 SHALL have core-status inputs: I_ACC in 24 accumulator; I_SOE in 1 solenoid-enable; I_RTE in 1 runtime-exceeded.

Function
REQ-007 Register map SHALL be: 0x0 CTRL; 0x1/0x2/0x3 DLY bytes low/mid/high; 0x4/0x5/0x6 LMT bytes low/mid/high; 0x7 STATUS; 0x8/0x9/0xA CAP bytes low/mid/high.
REQ-008 CTRL bits SHALL be: bit0 EN, bit1 OE, bit2 DDS, bit3 LDS, bit4 LEN, bits7:5 read 0; a CTRL write drives the config outputs on the next cycle.
REQ-009 Writes to DLY/LMT low and mid bytes SHALL update staging bytes only; a write to the high byte SHALL commit the {high, mid-stage, low-stage} 24-bit value to O_DLY/O_LMT in the next cycle, atomically.
REQ-010 Reads of 0x1-0x6 SHALL return the committed byte, not the staged byte.
REQ-011 STATUS SHALL be: bit0 RTE_STICKY, bit1 CAP_VALID, bit2 BUSY (live I_SOE), bits7:3 0.
REQ-012 A rising edge of I_RTE, detected via a one-cycle-delayed register, SHALL set RTE_STICKY.
REQ-013 A falling edge of I_SOE SHALL capture I_ACC of that same cycle into CAP and set CAP_VALID.
REQ-014 A read of STATUS SHALL return the pre-clear value, then clear RTE_STICKY and CAP_VALID.
REQ-015 If a set event and a clearing STATUS read occur in the same cycle, the set SHALL win: the flag is 1 afterward and the read returns the old value.
REQ-016 A read of 0x8 SHALL snapshot all 24 CAP bits into a read-hold register and return the low byte; reads of 0x9/0xA SHALL return the hold register, so the bytes are coherent even if a capture lands between byte reads.
REQ-017 Read latency SHALL be exactly 1 cycle: O_RDATA is valid while O_RVALID=1, the cycle after I_RE; at other times O_RDATA holds its last value.
REQ-018 When I_WE and I_RE are both 1, the write SHALL execute and the read SHALL be ignored (O_RVALID stays 0).
REQ-019 Unmapped addresses SHALL read 0x00 with O_RVALID=1; writes to them and to 0x7-0xA SHALL be ignored.
REQ-020 Back-to-back accesses every cycle SHALL be supported with no stall.

Reset
REQ-021 I_RST=1 at a clk edge SHALL clear CTRL, staging, O_DLY, O_LMT, CAP, the hold register, the sticky flags, the edge registers, O_RDATA and O_RVALID to 0.
REQ-022 Reset mid-sequence SHALL discard staged bytes; a later high-byte write commits with zero low/mid bytes.
REQ-023 With I_RST=1, host strobes and status edges SHALL be ignored.

Structure
REQ-024 Register addresses, CTRL/STATUS bit positions and the 24-bit width SHALL live in shared package cg_pkg.
REQ-025 The staged 24-bit register SHALL be one sub-module, cg_stage24, instantiated twice (DLY, LMT).

Verification
REQ-026 Write 0x1=0x56, 0x2=0x34 -> O_DLY stays 0; write 0x3=0x12 -> O_DLY=0x123456 exactly one cycle later.
REQ-027 Write CTRL=0x13 -> O_EN=1, O_OE=1, O_LEN=1, O_DDS=0, O_LDS=0; read 0x0 -> O_RDATA=0x13 with O_RVALID the next cycle.
REQ-028 I_ACC=0x00A0F0 with I_SOE 1->0 -> read STATUS=0x02, re-read=0x00; reads 0x8/0x9/0xA=0xF0/0xA0/0x00.
REQ-029 Read 0x8, then a new capture of 0x111111, then read 0x9 -> old mid byte returned; next 0x8 read yields 0x11.
REQ-030 I_RTE rises in the same cycle as a STATUS read -> the read returns bit0=0 and the next read returns bit0=1.
REQ-031 Assert I_RST after writing 0x4=0xFF -> all outputs 0; then write 0x6=0x01 -> O_LMT=0x010000.
